// File: rtl/touch_hold_tracker.sv
// rtl/touch_hold_tracker.sv - debounced quadrant latch with ms hold timer, BCD display and periodic change pulse
module touch_hold_tracker #(
   parameter int CLKS_PER_MS = 50000,
   parameter int HOLD_MS     = 1000
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Touch_En,
   input  logic        Coord_En,
   input  logic [11:0] X_Coord,
   input  logic [11:0] Y_Coord,
   output logic        Quad_Valid,
   output logic [1:0]  Quad,
   output logic [15:0] Hold_BCD,
   output logic        Change_Pulse,
   output logic [1:0]  Change_Quad
);

   // A one-cycle ms period still needs a 1-bit prescaler register
   localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam int HW = $clog2(HOLD_MS + 1);
   localparam logic [PW-1:0] PRE_MAX   = PW'(CLKS_PER_MS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MS - 1);

   typedef enum logic [1:0] {IDLE, WAIT_COORD, HOLDING} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   prescaler, prescaler_nxt;
   logic [HW-1:0]   hold_cnt, hold_cnt_nxt;
   logic [15:0]     bcd_nxt;
   logic [1:0]      quad_nxt, change_quad_nxt;
   logic            quad_valid_nxt, change_pulse_nxt;
   logic [1:0]      new_quad;
   logic            tick;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      if (v == 16'h9999) return v;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign new_quad = {X_Coord[11], Y_Coord[11]};
   assign tick     = (prescaler == PRE_MAX);

   always_comb begin
      state_nxt        = state;
      prescaler_nxt    = prescaler;
      hold_cnt_nxt     = hold_cnt;
      bcd_nxt          = Hold_BCD;
      quad_nxt         = Quad;
      quad_valid_nxt   = Quad_Valid;
      change_pulse_nxt = 1'b0;
      change_quad_nxt  = Change_Quad;
      case (state)
         IDLE: begin
            quad_valid_nxt = 1'b0;
            prescaler_nxt  = '0;
            hold_cnt_nxt   = '0;
            bcd_nxt        = 16'h0000;
            if (Touch_En) state_nxt = WAIT_COORD;
         end
         WAIT_COORD: begin
            if (!Touch_En) begin
               state_nxt = IDLE;
            end else if (Coord_En) begin
               state_nxt      = HOLDING;
               quad_nxt       = new_quad;
               quad_valid_nxt = 1'b1;
               prescaler_nxt  = '0;
               hold_cnt_nxt   = '0;
               bcd_nxt        = 16'h0000;
            end
         end
         HOLDING: begin
            if (!Touch_En) begin
               state_nxt      = IDLE;
               quad_valid_nxt = 1'b0;
               prescaler_nxt  = '0;
               hold_cnt_nxt   = '0;
               bcd_nxt        = 16'h0000;
            end else if (Coord_En && (new_quad != Quad)) begin
               // A move restarts timing and swallows any tick on this edge
               quad_nxt      = new_quad;
               prescaler_nxt = '0;
               hold_cnt_nxt  = '0;
               bcd_nxt       = 16'h0000;
            end else begin
               prescaler_nxt = tick ? '0 : prescaler + PW'(1);
               if (tick) begin
                  bcd_nxt = bcd_inc(Hold_BCD);
                  if (hold_cnt == HOLD_LAST) begin
                     hold_cnt_nxt     = '0;
                     change_pulse_nxt = 1'b1;
                     change_quad_nxt  = Quad;
                  end else begin
                     hold_cnt_nxt = hold_cnt + HW'(1);
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state        <= IDLE;
         prescaler    <= '0;
         hold_cnt     <= '0;
         Hold_BCD     <= 16'h0000;
         Quad         <= 2'b00;
         Quad_Valid   <= 1'b0;
         Change_Pulse <= 1'b0;
         Change_Quad  <= 2'b00;
      end else begin
         state        <= state_nxt;
         prescaler    <= prescaler_nxt;
         hold_cnt     <= hold_cnt_nxt;
         Hold_BCD     <= bcd_nxt;
         Quad         <= quad_nxt;
         Quad_Valid   <= quad_valid_nxt;
         Change_Pulse <= change_pulse_nxt;
         Change_Quad  <= change_quad_nxt;
      end
   end

endmodule

// File: tb/tb_touch_hold_tracker.sv
// tb/tb_touch_hold_tracker.sv - self-checking bench for touch_hold_tracker
module tb_touch_hold_tracker;

   logic        Clock;
   logic        Resetn;
   logic        te [2];
   logic        ce [2];
   logic [11:0] xc [2];
   logic [11:0] yc [2];
   logic        qv [2];
   logic [1:0]  q  [2];
   logic [15:0] bcd[2];
   logic        cp [2];
   logic [1:0]  cq [2];

   int n_assert = 0;
   int n_fail   = 0;
   int n        = 0;
   int pulses[2];

   // Reference model: pen phase, latch edge and quadrant; hold time derived from elapsed edges
   localparam int P_UP = 0, P_DOWN = 1, P_TIMED = 2;
   int          m_phase[2];
   int          m_start[2];
   logic        m_valid[2];
   logic [1:0]  m_quad [2];
   logic [1:0]  m_cq   [2];
   logic        m_pulse[2];

   touch_hold_tracker #(.CLKS_PER_MS(4), .HOLD_MS(3)) dut_a (
      .Clock(Clock), .Resetn(Resetn), .Touch_En(te[0]), .Coord_En(ce[0]),
      .X_Coord(xc[0]), .Y_Coord(yc[0]), .Quad_Valid(qv[0]), .Quad(q[0]),
      .Hold_BCD(bcd[0]), .Change_Pulse(cp[0]), .Change_Quad(cq[0]));

   touch_hold_tracker #(.CLKS_PER_MS(1), .HOLD_MS(9999)) dut_b (
      .Clock(Clock), .Resetn(Resetn), .Touch_En(te[1]), .Coord_En(ce[1]),
      .X_Coord(xc[1]), .Y_Coord(yc[1]), .Quad_Valid(qv[1]), .Quad(q[1]),
      .Hold_BCD(bcd[1]), .Change_Pulse(cp[1]), .Change_Quad(cq[1]));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   function automatic int cpm(int d);
      return (d == 0) ? 4 : 1;
   endfunction

   function automatic int hms(int d);
      return (d == 0) ? 3 : 9999;
   endfunction

   function automatic logic [15:0] to_bcd(int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic chk(string tag, int d, logic [15:0] obs, logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[%0d] observed=%h expected=%h", tag, d, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_phase[d] = P_UP;
         m_start[d] = 0;
         m_valid[d] = 1'b0;
         m_quad[d]  = 2'b00;
         m_cq[d]    = 2'b00;
         m_pulse[d] = 1'b0;
      end
   endtask

   task automatic model_update(int d);
      logic [1:0] nq;
      int         el;
      nq         = {xc[d][11], yc[d][11]};
      m_pulse[d] = 1'b0;
      if (!te[d]) begin
         m_phase[d] = P_UP;
         m_valid[d] = 1'b0;
      end else if (m_phase[d] == P_UP) begin
         m_phase[d] = P_DOWN;
      end else if (m_phase[d] == P_DOWN) begin
         if (ce[d]) begin
            m_phase[d] = P_TIMED;
            m_quad[d]  = nq;
            m_valid[d] = 1'b1;
            m_start[d] = n;
         end
      end else if (ce[d] && nq != m_quad[d]) begin
         m_quad[d]  = nq;
         m_start[d] = n;
      end else begin
         el = n - m_start[d];
         if (el % (hms(d) * cpm(d)) == 0) begin
            m_pulse[d] = 1'b1;
            m_cq[d]    = m_quad[d];
         end
      end
   endtask

   task automatic model_check(int d);
      int ms;
      ms = (n - m_start[d]) / cpm(d);
      if (ms > 9999) ms = 9999;
      chk("quad_valid", d, {15'b0, qv[d]}, {15'b0, m_valid[d]});
      chk("quad", d, {14'b0, q[d]}, {14'b0, m_quad[d]});
      chk("hold_bcd", d, bcd[d], m_valid[d] ? to_bcd(ms) : 16'h0000);
      chk("change_pulse", d, {15'b0, cp[d]}, {15'b0, m_pulse[d]});
      chk("change_quad", d, {14'b0, cq[d]}, {14'b0, m_cq[d]});
   endtask

   task automatic step();
      @(posedge Clock);
      n++;
      model_update(0);
      model_update(1);
      @(negedge Clock);
      for (int d = 0; d < 2; d++) begin
         model_check(d);
         if (cp[d]) pulses[d]++;
      end
   endtask

   task automatic cyc(logic t, logic c, logic [11:0] x, logic [11:0] y);
      te[0] = t; ce[0] = c; xc[0] = x; yc[0] = y;
      step();
   endtask

   initial begin
      int pc;
      Resetn = 1'b0;
      for (int d = 0; d < 2; d++) begin
         te[d] = 1'b0; ce[d] = 1'b0; xc[d] = 12'h000; yc[d] = 12'h000;
         pulses[d] = 0;
      end
      model_reset();
      #22;
      chk("rst_quad_valid", 0, {15'b0, qv[0]}, 16'h0000);
      chk("rst_bcd", 0, bcd[0], 16'h0000);
      chk("rst_pulse", 0, {15'b0, cp[0]}, 16'h0000);
      chk("rst_cquad", 0, {14'b0, cq[0]}, 16'h0000);
      @(negedge Clock);
      Resetn = 1'b1;

      // Long hold in the top-right quadrant
      cyc(1, 0, 12'h000, 12'h000);
      cyc(1, 1, 12'h900, 12'h100);
      chk("s1_quad", 0, {14'b0, q[0]}, 16'h0002);
      chk("s1_valid", 0, {15'b0, qv[0]}, 16'h0001);
      pc = pulses[0];
      for (int i = 1; i <= 40; i++) begin
         cyc(1, 0, 12'h000, 12'h000);
         if (i == 4)  chk("s1_bcd4", 0, bcd[0], 16'h0001);
         if (i == 8)  chk("s1_bcd8", 0, bcd[0], 16'h0002);
         if (i == 12) chk("s1_pulse12", 0, {14'b0, cp[0], cq[0]}, 16'h0006);
         if (i == 13) chk("s1_pulse13", 0, {15'b0, cp[0]}, 16'h0000);
         if (i == 24) chk("s1_pulse24", 0, {15'b0, cp[0]}, 16'h0001);
      end
      chk("s1_bcd40", 0, bcd[0], 16'h0010);
      chk("s1_npulse", 0, 16'(pulses[0] - pc), 16'd3);

      // Quadrant move after 10 cycles restarts the period
      cyc(0, 0, 12'h000, 12'h000);
      cyc(1, 0, 12'h000, 12'h000);
      cyc(1, 1, 12'h900, 12'h100);
      for (int i = 0; i < 10; i++) cyc(1, 0, 12'h000, 12'h000);
      cyc(1, 1, 12'h100, 12'h900);
      chk("s2_quad", 0, {14'b0, q[0]}, 16'h0001);
      chk("s2_bcd", 0, bcd[0], 16'h0000);
      for (int i = 1; i <= 12; i++) begin
         cyc(1, 0, 12'h000, 12'h000);
         if (i < 12) chk("s2_nopulse", 0, {15'b0, cp[0]}, 16'h0000);
         else        chk("s2_pulse", 0, {14'b0, cp[0], cq[0]}, 16'h0005);
      end

      // Release before the first pulse
      cyc(0, 0, 12'h000, 12'h000);
      cyc(1, 0, 12'h000, 12'h000);
      cyc(1, 1, 12'h900, 12'h900);
      for (int i = 0; i < 10; i++) cyc(1, 0, 12'h000, 12'h000);
      cyc(0, 0, 12'h000, 12'h000);
      chk("s3_valid", 0, {15'b0, qv[0]}, 16'h0000);
      chk("s3_bcd", 0, bcd[0], 16'h0000);
      chk("s3_pulse_cq", 0, {14'b0, cp[0], cq[0]}, 16'h0001);
      chk("s3_quad", 0, {14'b0, q[0]}, 16'h0003);

      // Quadrant move exactly on a tick edge
      cyc(1, 0, 12'h000, 12'h000);
      cyc(1, 1, 12'h000, 12'h000);
      for (int i = 0; i < 3; i++) cyc(1, 0, 12'h000, 12'h000);
      cyc(1, 1, 12'h800, 12'h000);
      chk("s4_bcd", 0, bcd[0], 16'h0000);
      for (int i = 1; i <= 12; i++) begin
         cyc(1, 0, 12'h000, 12'h000);
         if (i == 4) chk("s4_bcd4", 0, bcd[0], 16'h0001);
         if (i < 12) chk("s4_nopulse", 0, {15'b0, cp[0]}, 16'h0000);
         else        chk("s4_pulse", 0, {14'b0, cp[0], cq[0]}, 16'h0006);
      end

      // Release on the pulse edge
      cyc(0, 0, 12'h000, 12'h000);
      cyc(1, 0, 12'h000, 12'h000);
      cyc(1, 1, 12'h800, 12'h800);
      for (int i = 0; i < 11; i++) cyc(1, 0, 12'h000, 12'h000);
      cyc(0, 0, 12'h000, 12'h000);
      chk("s5_nopulse", 0, {15'b0, cp[0], qv[0]}, 16'h0000);
      cyc(0, 0, 12'h000, 12'h000);
      chk("s5_nopulse2", 0, {15'b0, cp[0]}, 16'h0000);

      // Strobe while pen up is ignored
      cyc(0, 1, 12'hfff, 12'h000);
      chk("s6_idle_valid", 0, {15'b0, qv[0]}, 16'h0000);
      chk("s6_idle_quad", 0, {14'b0, q[0]}, 16'h0003);
      cyc(1, 0, 12'h000, 12'h000);
      chk("s6_wait_valid", 0, {15'b0, qv[0]}, 16'h0000);

      // Asynchronous reset mid-hold
      cyc(1, 1, 12'h900, 12'h100);
      for (int i = 0; i < 14; i++) cyc(1, 0, 12'h000, 12'h000);
      Resetn = 1'b0;
      #1;
      chk("ar_valid", 0, {15'b0, qv[0]}, 16'h0000);
      chk("ar_quad", 0, {14'b0, q[0]}, 16'h0000);
      chk("ar_bcd", 0, bcd[0], 16'h0000);
      chk("ar_cquad", 0, {14'b0, cq[0]}, 16'h0000);
      model_reset();
      #1;
      Resetn = 1'b1;
      cyc(0, 0, 12'h000, 12'h000);

      // Randomised pen and strobe activity
      for (int i = 0; i < 1500; i++) begin
         logic t;
         t = te[0];
         if (t) begin
            if ($urandom_range(0, 49) == 0) t = 1'b0;
         end else if ($urandom_range(0, 4) == 0) begin
            t = 1'b1;
         end
         cyc(t, ($urandom_range(0, 29) == 0), 12'($urandom), 12'($urandom));
      end
      cyc(0, 0, 12'h000, 12'h000);

      // Full BCD range with one-cycle ms
      te[1] = 1'b1;
      step();
      ce[1] = 1'b1; xc[1] = 12'h000; yc[1] = 12'h000;
      step();
      ce[1] = 1'b0;
      pc = pulses[1];
      for (int i = 1; i <= 10010; i++) begin
         step();
         if (i == 9)     chk("b_bcd9", 1, bcd[1], 16'h0009);
         if (i == 99)    chk("b_bcd99", 1, bcd[1], 16'h0099);
         if (i == 999)   chk("b_bcd999", 1, bcd[1], 16'h0999);
         if (i == 9999)  chk("b_pulse9999", 1, {bcd[1][15:1], cp[1]}, 16'h9999);
         if (i == 10010) chk("b_sat", 1, bcd[1], 16'h9999);
      end
      chk("b_npulse", 1, 16'(pulses[1] - pc), 16'd1);
      te[1] = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
